// File: rtl/ce_generator.sv
// ce_generator: clock-enable source for the modulo-N counters. Run mode pulses CE every DIV
// clocks; stop mode gives one CE per push-button press. Define CE_GENERATOR_DEBOUNCE_EN to debounce the button.
module ce_generator #(
  parameter int DIV             = 100,
  parameter int WIDTH           = (DIV > 1) ? $clog2(DIV) : 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP_BTN,
  output logic       CE,
  output logic [1:0] STATE
);

  localparam logic [1:0] S_STOP = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;

  localparam logic [WIDTH-1:0] PRESC_LAST = WIDTH'(DIV - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (DIV < 1) begin : g_bad_div
    $error("ce_generator: DIV must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ce_generator: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("ce_generator: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_s;
  logic                   r_db_lvl;
  logic                   r_step_evt;
  logic [1:0]             r_state;
  logic [WIDTH-1:0]       r_presc;
  logic                   r_ce;

  always_ff @(posedge CLK) begin
    if (!RST) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], STEP_BTN};
  end

  assign w_btn_s = r_sync[SYNC_STAGES-1];

`ifdef CE_GENERATOR_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_lvl_d;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // the rising edge of the accepted level is then registered once more as step_evt.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_db_cnt   <= '0;
      r_db_lvl   <= 1'b0;
      r_db_lvl_d <= 1'b0;
      r_step_evt <= 1'b0;
    end else begin
      r_db_lvl_d <= r_db_lvl;
      r_step_evt <= r_db_lvl & ~r_db_lvl_d;
      if (w_btn_s == r_db_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_lvl <= w_btn_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end
`else
  // No filtering: every synchronised rising edge, bounces included, becomes a step.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_db_lvl   <= 1'b0;
      r_step_evt <= 1'b0;
    end else begin
      r_db_lvl   <= w_btn_s;
      r_step_evt <= w_btn_s & ~r_db_lvl;
    end
  end
`endif

  // RUN wins over a coincident step_evt in STOP; steps arriving outside STOP are dropped.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_STOP;
      r_presc <= '0;
      r_ce    <= 1'b0;
    end else begin
      r_ce <= 1'b0;
      case (r_state)
        S_STOP: begin
          if (RUN) begin
            r_state <= S_RUN;
            r_presc <= '0;
          end else if (r_step_evt) begin
            r_state <= S_STEP;
            r_ce    <= 1'b1;
          end
        end
        S_RUN: begin
          if (!RUN) begin
            r_state <= S_STOP;
            r_presc <= '0;
          end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_ce    <= 1'b1;
          end else begin
            r_presc <= r_presc + WIDTH'(1);
          end
        end
        S_STEP: begin
          r_state <= RUN ? S_RUN : S_STOP;
          r_presc <= '0;
        end
        default: begin
          r_state <= S_STOP;
          r_presc <= '0;
        end
      endcase
    end
  end

  assign CE    = r_ce;
  assign STATE = r_state;

endmodule

// File: tb/tb_ce_generator.sv
// tb_ce_generator: three ce_generator instances with different DIV / sync / debounce settings,
// driven by shared directed and random stimulus and compared against a cycle-level reference model.
module tb_ce_generator;

  localparam int NI  = 3;
  localparam int DIV0 = 4,  SS0 = 2, DB0 = 16;
  localparam int DIV1 = 10, SS1 = 3, DB1 = 5;
  localparam int DIV2 = 1,  SS2 = 2, DB2 = 3;
`ifdef CE_GENERATOR_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  int divs[NI] = '{DIV0, DIV1, DIV2};
  int sss[NI]  = '{SS0, SS1, SS2};
  int dbs[NI]  = '{DB0, DB1, DB2};

  logic CLK = 1'b0;
  logic RST, RUN, STEP_BTN;
  logic [NI-1:0]      ce;
  logic [NI-1:0][1:0] st;

  always #5 CLK = ~CLK;

  ce_generator #(.DIV(DIV0), .SYNC_STAGES(SS0), .DEBOUNCE_CYCLES(DB0)) u_dut0 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP_BTN(STEP_BTN), .CE(ce[0]), .STATE(st[0]));
  ce_generator #(.DIV(DIV1), .SYNC_STAGES(SS1), .DEBOUNCE_CYCLES(DB1)) u_dut1 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP_BTN(STEP_BTN), .CE(ce[1]), .STATE(st[1]));
  ce_generator #(.DIV(DIV2), .SYNC_STAGES(SS2), .DEBOUNCE_CYCLES(DB2)) u_dut2 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP_BTN(STEP_BTN), .CE(ce[2]), .STATE(st[2]));

  // Reference model: raw button history, per-instance debounce view, mode (0 stop,1 run,2 step)
  // and cycles elapsed since run entry.
  bit hist[$];
  bit m_bs[NI], m_lvl[NI], m_rose[NI], m_evt[NI], m_ce[NI];
  int m_cnt[NI], m_mode[NI], m_since[NI];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit rst, input bit run, input bit raw);
    bit bs_old, nlvl, nevt, nrose;
    int ncnt;
    if (!rst) begin
      hist.delete();
      for (int i = 0; i < NI; i++) begin
        m_bs[i] = 0; m_lvl[i] = 0; m_rose[i] = 0; m_evt[i] = 0; m_ce[i] = 0;
        m_cnt[i] = 0; m_mode[i] = 0; m_since[i] = 0;
      end
      return;
    end
    hist.push_back(raw);
    if (hist.size() > 8) void'(hist.pop_front());
    for (int i = 0; i < NI; i++) begin
      bs_old = m_bs[i];
      nlvl   = m_lvl[i];
      nrose  = 0;
      ncnt   = 0;
      if (DB_EN) begin
        if (bs_old != m_lvl[i]) begin
          if (m_cnt[i] + 1 == dbs[i]) nlvl = bs_old;
          else                        ncnt = m_cnt[i] + 1;
        end
        nrose = nlvl & ~m_lvl[i];
        nevt  = m_rose[i];
      end else begin
        nlvl = bs_old;
        nevt = bs_old & ~m_lvl[i];
      end
      case (m_mode[i])
        0: begin
          m_ce[i] = 0;
          if (run) begin
            m_mode[i] = 1; m_since[i] = 0;
          end else if (m_evt[i]) begin
            m_mode[i] = 2; m_ce[i] = 1;
          end
        end
        1: begin
          if (!run) begin
            m_mode[i] = 0; m_ce[i] = 0;
          end else begin
            m_since[i]++;
            m_ce[i] = (m_since[i] % divs[i] == 0);
          end
        end
        default: begin
          m_mode[i] = run ? 1 : 0; m_since[i] = 0; m_ce[i] = 0;
        end
      endcase
      m_bs[i]   = (hist.size() >= sss[i]) ? hist[hist.size() - sss[i]] : 1'b0;
      m_lvl[i]  = nlvl;
      m_cnt[i]  = ncnt;
      m_evt[i]  = nevt;
      m_rose[i] = nrose;
    end
  endfunction

  task automatic cyc(input bit rst, input bit run, input bit btn);
    RST = rst; RUN = run; STEP_BTN = btn;
    @(posedge CLK);
    model_edge(rst, run, btn);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ce%0d", i), int'(ce[i]), int'(m_ce[i]));
      chk($sformatf("state%0d", i), int'(st[i]), m_mode[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, lat, lat_exp, rises, bad;
    bit b, prev, run_r, btn_r, noisy;

    // Reset held with RUN and the button asserted
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1);
      chk("rst_ce", int'(ce[0]), 0);
      chk("rst_state", int'(st[0]), 0);
    end
    cyc(1, 1, 0);
    chk("rst_exit_state", int'(st[0]), 1);

    // DIV=4: four single-cycle pulses in 16 cycles after entry
    cnt = 0;
    for (int k = 0; k < 16; k++) begin cyc(1, 1, 0); cnt += int'(ce[0]); end
    chk("div4_pulses16", cnt, 4);

    // DIV=10 interrupted run
    for (int k = 0; k < 3; k++) cyc(1, 0, 0);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin cyc(1, 1, 0); cnt += int'(ce[1]); end
    chk("div10_partial_ce", cnt, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0);
    first = -1;
    for (int k = 0; k < 30 && first < 0; k++) begin
      cyc(1, 1, 0);
      if (ce[1]) first = k;
    end
    chk("div10_reentry_first", first, 10);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0);

    // DIV=1: CE continuous from the cycle after entry, drops on stop
    cyc(1, 1, 0);
    chk("div1_entry_ce", int'(ce[2]), 0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin cyc(1, 1, 0); cnt += int'(ce[2]); end
    chk("div1_run_ce", cnt, 5);
    cyc(1, 0, 0);
    chk("div1_stop_ce", int'(ce[2]), 0);

    // Clean press: latency, single pulse for a long hold, silent release
    lat_exp = DB_EN ? SS0 + DB0 + 2 : SS0 + 2;
    for (int k = 0; k < 40; k++) cyc(1, 0, 0);
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      cyc(1, 0, 1);
      if (ce[0]) lat = k;
    end
    chk("press_latency", lat, lat_exp);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin cyc(1, 0, 1); cnt += int'(ce[0]); end
    chk("hold_extra_ce", cnt, 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin cyc(1, 0, 0); cnt += int'(ce[0]); end
    chk("release_ce", cnt, 0);

    // Bouncing press then bouncing release
    cnt = 0; rises = 0; bad = 0; prev = 0;
    for (int c = 0; c < 122; c++) begin
      if (c < 30)       b = ((c / 3) % 2) == 0;
      else if (c < 70)  b = 1;
      else if (c < 82)  b = (((c - 70) / 3) % 2) == 1;
      else              b = 0;
      if (b && !prev) rises++;
      prev = b;
      cyc(1, 0, b);
      cnt += int'(ce[0]);
      if (ce[0] && st[0] != 2'b10) bad++;
    end
    chk("bounce_pulses", cnt, DB_EN ? 1 : rises);
    chk("bounce_ce_state", bad, 0);

    // Step event and RUN on the same edge: run wins, first CE after DIV cycles
    for (int k = 0; k < 40; k++) cyc(1, 0, 0);
    for (int k = 1; k < lat_exp; k++) cyc(1, 0, 1);
    cyc(1, 1, 1);
    chk("collide_state", int'(st[0]), 1);
    chk("collide_ce", int'(ce[0]), 0);
    first = -1;
    for (int k = 1; k <= 30 && first < 0; k++) begin
      cyc(1, 1, 1);
      if (ce[0]) first = k;
    end
    chk("collide_first_ce", first, DIV0);
    for (int k = 0; k < 40; k++) cyc(1, 0, 0);

    // Random traffic with occasional mid-run / mid-debounce reset
    run_r = 0; btn_r = 0; noisy = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 50 == 0) noisy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) run_r = ~run_r;
      if (noisy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0)) btn_r = ~btn_r;
      cyc(($urandom_range(0, 599) != 0), run_r, btn_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ce_generator.md
Name: ce_generator

Overview:
- Upstream stage for the modulo-N counters. Drives their CE input so they count at a slow, visible rate instead of every CLK cycle.
- Two modes:
  - Run: one-cycle CE pulse every DIV clocks.
  - Single-step: one CE pulse per debounced press of a board push-button.
- Lives in the same top level as the counters; its CE output fans out to every counter instance.

Parameters:
- DIV, default 100: prescale ratio; CE period in run mode, in CLK cycles. Legal range is 1 or more.
- WIDTH, default $clog2(DIV): prescaler width, derived. Use max(1, $clog2(DIV)) so DIV=1 still gives a 1-bit register.
- SYNC_STAGES, default 2: flip-flop depth of the STEP_BTN synchroniser. Legal range is 2 or more.
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronised samples needed to accept a new button level. Legal range is 1 or more.

Ports:
- CLK, input, 1: system clock. Every register is on the rising edge.
- RST, input, 1: reset, synchronous, active-low. Sampled on the CLK rising edge; 0 resets all state.
- RUN, input, 1: level input, synchronous to CLK. 1 requests run mode, 0 requests stop.
- STEP_BTN, input, 1: raw asynchronous push-button, active-high, bouncing.
- CE, output, 1: registered clock-enable pulse to the downstream counters.
- STATE, output, 2: registered FSM state. STOP=00, RUN=01, STEP=10; 11 is never driven.

Behaviour:
- Reset (RST=0 at an edge): STATE=STOP, CE=0, prescaler=0, synchroniser flops=0, debounced level=0, stability counter=0.
- Synchroniser: STEP_BTN passes through SYNC_STAGES flops; btn_s is the last stage.
- Debouncer:
  - Stability counter clears whenever btn_s equals the debounced level.
  - Otherwise it increments each cycle.
  - On the edge where it would reach DEBOUNCE_CYCLES: the debounced level takes btn_s and the counter clears.
  - A one-cycle step_evt is registered on a 0->1 change of the debounced level.
- FSM, evaluated every edge:
  - STOP:
    - RUN=1 -> RUN state; prescaler cleared to 0.
    - else step_evt=1 -> STEP.
    - RUN has priority when both occur on the same edge; that step_evt is dropped.
  - RUN:
    - RUN=0 -> STOP; prescaler cleared. A partially counted period is discarded with no CE.
    - Otherwise the prescaler increments and wraps DIV-1 -> 0.
  - STEP: always exits after one cycle. RUN=1 -> RUN, else -> STOP.
- CE generation (CE is a register):
  - In STOP, CE=0.
  - In RUN, CE=1 for exactly the one cycle following the edge where the prescaler wraps DIV-1 -> 0.
  - First CE after entering RUN is high during cycle DIV, counting the entry edge as cycle 0. After that, CE is high every DIV cycles.
  - DIV=1: CE is continuously 1 while in RUN, starting the cycle after entry.
  - STEP state: CE=1 for exactly that one cycle.
- step_evt is ignored in RUN and STEP; button presses during run are lost by design.
- Each press gives exactly one CE pulse, regardless of press length. The release edge is debounced but produces no event.
- Reset asserted mid-run or mid-debounce: on the next edge everything returns to reset values and CE=0 immediately.
- Press-to-CE latency from STOP: SYNC_STAGES + DEBOUNCE_CYCLES + 2 edges after STEP_BTN is first sampled high and held clean.

Optional Feature:
- Macro: CE_GENERATOR_DEBOUNCE_EN.
- Defined: debouncer as described above.
- Undefined:
  - Debouncer is removed; DEBOUNCE_CYCLES is unused.
  - The debounced level is simply btn_s delayed one flop.
  - step_evt is the 0->1 edge of btn_s.
  - Latency becomes SYNC_STAGES + 2 edges.
  - Every bounce edge produces a step.

Test Plan:
- Reset: hold RST=0 for 3 cycles with RUN=1 and STEP_BTN=1 -> CE=0, STATE=00 throughout. First edge after RST=1 -> STATE=01.
- Run, DIV=4: RUN=1 from reset release -> CE pulses 1 cycle wide with 3 low cycles between. A mod-4 counter on CE reads 0,1,2,3,0 across 16 cycles.
- Run interruption: DIV=10, RUN=1 for 7 cycles then 0 for 5, then 1 -> no CE during the first 7 cycles. Next CE is exactly 10 cycles after RUN is re-entered.
- Bouncing step, DEBOUNCE_CYCLES=16, macro defined:
  - Stimulus: STEP_BTN toggles every 3 cycles for 30 cycles, then holds 1 for 40 cycles, then bounces and releases.
  - Required: exactly one CE pulse, 1 cycle wide, STATE shows 10 for that cycle.
  - Required, macro undefined: one CE per clean rising edge of btn_s.
- Step vs run collision: in STOP, step_evt and RUN=1 on the same edge -> STATE goes to 01, no immediate CE. First CE after DIV cycles.
- DIV=1: RUN=1 for 5 cycles -> CE high for 5 consecutive cycles. RUN=0 -> CE low on the next cycle.
